// File: rtl/mcu_reg_pkg.sv
// rtl/mcu_reg_pkg.sv - register map constants for the MCU bus register bank
package mcu_reg_pkg;

    localparam logic [7:0] ADDR_ID      = 8'h00;
    localparam logic [7:0] ADDR_CTRL    = 8'h01;
    localparam logic [7:0] ADDR_LED     = 8'h02;
    localparam logic [7:0] ADDR_TONE_L  = 8'h03;
    localparam logic [7:0] ADDR_TONE_H  = 8'h04;
    localparam logic [7:0] ADDR_SCRATCH = 8'h05;
    localparam logic [7:0] ADDR_BEEP    = 8'h06;

    localparam int CTRL_SOUND  = 0;
    localparam int CTRL_LCDRST = 1;
    localparam int CTRL_LCDBK  = 2;

endpackage

// File: rtl/mcu_bus_sync.sv
// rtl/mcu_bus_sync.sv - MCU strobe synchronisers and single-shot write strobe
module mcu_bus_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cs_i,
    input  logic rd_i,
    input  logic wr_i,
    output logic rd_q_o,
    output logic wr_stb_o
);

    logic [STAGES-1:0] cs_sync_q;
    logic [STAGES-1:0] rd_sync_q;
    logic [STAGES-1:0] wr_sync_q;
    logic              wr_q;
    logic              wr_prev_q;

    assign wr_q = cs_sync_q[STAGES-1] & wr_sync_q[STAGES-1];

    // Shift each strobe through its own chain; remember last wr_q for edge detect
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cs_sync_q <= '0;
            rd_sync_q <= '0;
            wr_sync_q <= '0;
            wr_prev_q <= 1'b0;
        end else begin
            cs_sync_q <= {cs_sync_q[STAGES-2:0], cs_i};
            rd_sync_q <= {rd_sync_q[STAGES-2:0], rd_i};
            wr_sync_q <= {wr_sync_q[STAGES-2:0], wr_i};
            wr_prev_q <= wr_q;
        end
    end

    assign rd_q_o   = cs_sync_q[STAGES-1] & rd_sync_q[STAGES-1];
    assign wr_stb_o = wr_q & ~wr_prev_q;

endmodule

// File: rtl/mcu_reg_bank.sv
// rtl/mcu_reg_bank.sv - MCU bus register bank with tone generator; MCU_REG_BEEP_EN adds the self-timed beep
module mcu_reg_bank #(
    parameter logic [7:0] VERSION     = 8'h55,
    parameter int         LED_W       = 8,
    parameter logic [7:0] LED_RST     = 8'h55,
    parameter int         SYNC_STAGES = 2,
    parameter int         TICK_DIV    = 50000
) (
    input  logic             clk_i,
    input  logic             mcu_rst_i,
    input  logic             mcu_cs_i,
    input  logic             mcu_rd_i,
    input  logic             mcu_wr_i,
    input  logic [7:0]       mcu_addr_i8,
    input  logic [7:0]       mcu_wrdat_i8,
    output logic [7:0]       mcu_rddat_o8,
    output logic             sound_o,
    output logic [LED_W-1:0] led_o,
    output logic             lcd_rst_o,
    output logic             lcd_bk_o
);

    import mcu_reg_pkg::*;

    logic             rd_q;
    logic             wr_stb;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [15:0]      tone_div_q, tone_div_d;
    logic [7:0]       scratch_q, scratch_d;
    logic [15:0]      tone_cnt_q, tone_cnt_d;
    logic             tone_q, tone_d;
    logic             tone_clr;
    logic [7:0]       rddat_q, rddat_d;
    logic [7:0]       rd_val;
    logic [7:0]       led_rd;
    logic [7:0]       beep_rd;
    logic             beep_active;

    mcu_bus_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i    (clk_i),
        .rst_i    (mcu_rst_i),
        .cs_i     (mcu_cs_i),
        .rd_i     (mcu_rd_i),
        .wr_i     (mcu_wr_i),
        .rd_q_o   (rd_q),
        .wr_stb_o (wr_stb)
    );

    // Register writes on the single write strobe; tone registers also restart the tone
    always_comb begin
        ctrl_d     = ctrl_q;
        led_d      = led_q;
        tone_div_d = tone_div_q;
        scratch_d  = scratch_q;
        tone_clr   = 1'b0;
        if (wr_stb) begin
            case (mcu_addr_i8)
                ADDR_CTRL:    ctrl_d = mcu_wrdat_i8[2:0];
                ADDR_LED:     led_d = mcu_wrdat_i8[LED_W-1:0];
                ADDR_TONE_L: begin
                    tone_div_d[7:0] = mcu_wrdat_i8;
                    tone_clr        = 1'b1;
                end
                ADDR_TONE_H: begin
                    tone_div_d[15:8] = mcu_wrdat_i8;
                    tone_clr         = 1'b1;
                end
                ADDR_SCRATCH: scratch_d = mcu_wrdat_i8;
                default:      ;
            endcase
        end
    end

    // Tone counter runs 0..tone_div and toggles the tone on wrap; a zero divider parks it
    always_comb begin
        tone_cnt_d = tone_cnt_q + 16'd1;
        tone_d     = tone_q;
        if (tone_clr || (tone_div_q == 16'd0)) begin
            tone_cnt_d = 16'd0;
            tone_d     = 1'b0;
        end else if (tone_cnt_q == tone_div_q) begin
            tone_cnt_d = 16'd0;
            tone_d     = ~tone_q;
        end
    end

`ifdef MCU_REG_BEEP_EN
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    beep_q, beep_d;

    // A BEEP write (re)loads the count; otherwise the count drops once per tick down to 0
    always_comb begin
        presc_d = presc_q + PW'(1);
        beep_d  = beep_q;
        if (wr_stb && (mcu_addr_i8 == ADDR_BEEP)) begin
            presc_d = '0;
            beep_d  = mcu_wrdat_i8;
        end else if (presc_q == PW'(TICK_DIV - 1)) begin
            presc_d = '0;
            if (beep_q != 8'd0) begin
                beep_d = beep_q - 8'd1;
            end
        end
    end

    // Beep prescaler and remaining-tick count
    always_ff @(posedge clk_i or posedge mcu_rst_i) begin
        if (mcu_rst_i) begin
            presc_q <= '0;
            beep_q  <= 8'd0;
        end else begin
            presc_q <= presc_d;
            beep_q  <= beep_d;
        end
    end

    assign beep_rd     = beep_q;
    assign beep_active = (beep_q != 8'd0);
`else
    assign beep_rd     = 8'd0;
    assign beep_active = 1'b0;
`endif

    // Read map; narrow LED register is zero-extended
    always_comb begin
        led_rd                = 8'd0;
        led_rd[LED_W-1:0]     = led_q;
        rd_val                = 8'd0;
        case (mcu_addr_i8)
            ADDR_ID:      rd_val = VERSION;
            ADDR_CTRL:    rd_val = {5'd0, ctrl_q};
            ADDR_LED:     rd_val = led_rd;
            ADDR_TONE_L:  rd_val = tone_div_q[7:0];
            ADDR_TONE_H:  rd_val = tone_div_q[15:8];
            ADDR_SCRATCH: rd_val = scratch_q;
            ADDR_BEEP:    rd_val = beep_rd;
            default:      rd_val = 8'd0;
        endcase
        rddat_d = rd_q ? rd_val : 8'd0;
    end

    // Register file, tone state and registered read data
    always_ff @(posedge clk_i or posedge mcu_rst_i) begin
        if (mcu_rst_i) begin
            ctrl_q     <= 3'd0;
            led_q      <= LED_RST[LED_W-1:0];
            tone_div_q <= 16'd0;
            scratch_q  <= 8'd0;
            tone_cnt_q <= 16'd0;
            tone_q     <= 1'b0;
            rddat_q    <= 8'd0;
        end else begin
            ctrl_q     <= ctrl_d;
            led_q      <= led_d;
            tone_div_q <= tone_div_d;
            scratch_q  <= scratch_d;
            tone_cnt_q <= tone_cnt_d;
            tone_q     <= tone_d;
            rddat_q    <= rddat_d;
        end
    end

    assign mcu_rddat_o8 = rddat_q;
    assign led_o        = led_q;
    assign lcd_rst_o    = ctrl_q[CTRL_LCDRST];
    assign lcd_bk_o     = ctrl_q[CTRL_LCDBK];
    assign sound_o      = tone_q & (ctrl_q[CTRL_SOUND] | beep_active);

endmodule

// File: tb/tb_mcu_reg_bank.sv
// tb/tb_mcu_reg_bank.sv - self-checking bench for mcu_reg_bank
module tb_mcu_reg_bank;

    localparam int S  = 2;
    localparam int TD = 4;
    localparam int N  = 4096;
`ifdef MCU_REG_BEEP_EN
    localparam bit BEEP_ON = 1'b1;
`else
    localparam bit BEEP_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       cs, rd, wr;
    logic [7:0] addr, wdat;
    logic [7:0] rddat;
    logic       snd;
    logic [7:0] led;
    logic       lcd_rst, lcd_bk;

    int total;
    int bad;
    bit chk_en;

    mcu_reg_bank #(
        .VERSION     (8'h55),
        .LED_W       (8),
        .LED_RST     (8'h55),
        .SYNC_STAGES (S),
        .TICK_DIV    (TD)
    ) dut (
        .clk_i        (clk),
        .mcu_rst_i    (rst),
        .mcu_cs_i     (cs),
        .mcu_rd_i     (rd),
        .mcu_wr_i     (wr),
        .mcu_addr_i8  (addr),
        .mcu_wrdat_i8 (wdat),
        .mcu_rddat_o8 (rddat),
        .sound_o      (snd),
        .led_o        (led),
        .lcd_rst_o    (lcd_rst),
        .lcd_bk_o     (lcd_bk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, int got, int expv);
        total++;
        if (got != expv) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, got, expv, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    int         cyc;
    bit         wl [N];
    bit         rl [N];
    logic [2:0] m_ctrl;
    logic [7:0] m_led, m_scr;
    logic [15:0] m_div;
    int         m_tone_t0, m_beep_v, m_beep_t0;
    logic [7:0] e_rd, e_led;
    logic       e_snd, e_lrst, e_lbk;

    function automatic int beep_at(int c);
        int r;
        if (!BEEP_ON || m_beep_v == 0) return 0;
        r = m_beep_v - (c - m_beep_t0) / TD;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic bit tone_at(int c);
        if (m_div == 16'd0) return 1'b0;
        return (((c - m_tone_t0) / (int'(m_div) + 1)) % 2) == 1;
    endfunction

    function automatic logic [7:0] map_rd(logic [7:0] a, int c);
        case (a)
            8'h00:   return 8'h55;
            8'h01:   return {5'd0, m_ctrl};
            8'h02:   return m_led;
            8'h03:   return m_div[7:0];
            8'h04:   return m_div[15:8];
            8'h05:   return m_scr;
            8'h06:   return 8'(beep_at(c));
            default: return 8'h00;
        endcase
    endfunction

    function automatic void apply_write(logic [7:0] a, logic [7:0] d, int c);
        case (a)
            8'h01: m_ctrl = d[2:0];
            8'h02: m_led = d;
            8'h03: begin m_div[7:0] = d; m_tone_t0 = c; end
            8'h04: begin m_div[15:8] = d; m_tone_t0 = c; end
            8'h05: m_scr = d;
            8'h06: if (BEEP_ON) begin m_beep_v = int'(d); m_beep_t0 = c; end
            default: ;
        endcase
    endfunction

    function automatic void set_exp(int c);
        e_led  = m_led;
        e_lrst = m_ctrl[1];
        e_lbk  = m_ctrl[2];
        e_snd  = tone_at(c) && (m_ctrl[0] || beep_at(c) != 0);
    endfunction

    function automatic void model_reset();
        m_ctrl = 3'd0; m_led = 8'h55; m_scr = 8'd0; m_div = 16'd0;
        m_tone_t0 = 0; m_beep_v = 0; m_beep_t0 = 0;
        for (int k = 0; k <= S + 2; k++) begin
            wl[(cyc + N - k) % N] = 1'b0;
            rl[(cyc + N - k) % N] = 1'b0;
        end
        e_rd = 8'd0;
        set_exp(cyc);
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            model_reset();
        end else begin
            wl[cyc % N] = cs & wr;
            rl[cyc % N] = cs & rd;
            e_rd = rl[(cyc - S) % N] ? map_rd(addr, cyc - 1) : 8'd0;
            if (wl[(cyc - S) % N] && !wl[(cyc - S - 1) % N])
                apply_write(addr, wdat, cyc);
            set_exp(cyc);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_rddat", int'(rddat), int'(e_rd));
            check("cyc_led", int'(led), int'(e_led));
            check("cyc_lcd_rst", int'(lcd_rst), int'(e_lrst));
            check("cyc_lcd_bk", int'(lcd_bk), int'(e_lbk));
            check("cyc_sound", int'(snd), int'(e_snd));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d, input int hold);
        addr = a; wdat = d; cs = 1'b1; wr = 1'b1;
        tick(hold);
        wr = 1'b0; cs = rd;
        tick(2);
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        addr = a; cs = 1'b1; rd = 1'b1;
        tick(S + 1);
        d = rddat;
        rd = 1'b0; cs = 1'b0;
        tick(2);
    endtask

    int seq_q[$];
    task automatic collect(input int n);
        logic [7:0] last;
        seq_q.delete();
        last = rddat;
        repeat (n) begin
            @(negedge clk);
            if (rddat != last) begin
                seq_q.push_back(int'(rddat));
                last = rddat;
            end
        end
    endtask

    task automatic count_high(input int n, output int h);
        h = 0;
        repeat (n) begin
            tick(1);
            if (snd) h++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] rst_tab [8] = '{8'h55, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    int         seq1 [4]    = '{3, 2, 1, 0};
    int         seq2 [9]    = '{4, 3, 2, 5, 4, 3, 2, 1, 0};

    initial begin
        logic [7:0] d;
        int r1, r2, h, n;
        bit prev;
        total = 0; bad = 0; cyc = 0; chk_en = 1'b0;
        rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 8'd0; wdat = 8'd0;
        model_reset();
        tick(3);
        chk_en = 1'b1;
        rst = 1'b0;
        tick(1);

        check("rst_led", int'(led), 8'h55);
        check("rst_sound", int'(snd), 0);
        check("rst_rddat", int'(rddat), 0);
        for (int a = 0; a < 8; a++) begin
            bus_read(8'(a), d);
            check($sformatf("rst_read_%0d", a), int'(d), int'(rst_tab[a]));
        end

        bus_write(8'h01, 8'hFE, 4);
        bus_read(8'h01, d);   check("ctrl_mask", int'(d), 8'h06);
        bus_write(8'h07, 8'hFF, 4);
        bus_read(8'h07, d);   check("unmapped", int'(d), 8'h00);
        bus_write(8'h05, 8'h3C, 4);
        bus_read(8'h05, d);   check("scratch", int'(d), 8'h3C);
        bus_write(8'h04, 8'h12, 4);
        bus_read(8'h04, d);   check("tone_h", int'(d), 8'h12);
        bus_write(8'h01, 8'h00, 4);

        addr = 8'h02; wdat = 8'hA5; cs = 1'b1; wr = 1'b1;
        tick(S);     check("led_early", int'(led), 8'h55);
        tick(1);     check("led_latency", int'(led), 8'hA5);
        tick(37);
        wr = 1'b0; cs = 1'b0;
        tick(2);
        bus_read(8'h01, d);   check("ctrl_after_led", int'(d), 8'h00);

        bus_write(8'h01, 8'h01, 4);
        bus_write(8'h04, 8'h00, 4);
        bus_write(8'h03, 8'h04, 40);
        r1 = -1; r2 = -1; prev = snd;
        for (int i = 0; i < 60 && r2 < 0; i++) begin
            tick(1);
            if (snd && !prev) begin
                if (r1 < 0) r1 = i; else r2 = i;
            end
            prev = snd;
        end
        check("tone_period", (r2 >= 0) ? (r2 - r1) : -1, 10);
        bus_write(8'h01, 8'h00, 4);
        count_high(20, h);    check("sound_off", h, 0);

`ifdef MCU_REG_BEEP_EN
        bus_write(8'h03, 8'h01, 4);
        addr = 8'h06; cs = 1'b1; rd = 1'b1;
        tick(S + 1);
        fork
            collect(40);
            bus_write(8'h06, 8'h03, 4);
        join
        tick(1);
        check("beep_seq_len", seq_q.size(), 4);
        n = (seq_q.size() < 4) ? seq_q.size() : 4;
        for (int i = 0; i < n; i++) check($sformatf("beep_seq_%0d", i), seq_q[i], seq1[i]);
        fork
            collect(60);
            begin
                bus_write(8'h06, 8'h04, 4);
                tick(4);
                bus_write(8'h06, 8'h05, 4);
            end
        join
        tick(1);
        check("restart_len", seq_q.size(), 9);
        n = (seq_q.size() < 9) ? seq_q.size() : 9;
        for (int i = 0; i < n; i++) check($sformatf("restart_%0d", i), seq_q[i], seq2[i]);
        rd = 1'b0; cs = 1'b0;
        tick(2);
        count_high(20, h);    check("beep_silence", h, 0);
        bus_write(8'h06, 8'h03, 4);
        bus_write(8'h06, 8'h00, 4);
        bus_read(8'h06, d);   check("beep_cancel", int'(d), 0);
`else
        bus_write(8'h06, 8'h03, 4);
        bus_read(8'h06, d);   check("beep_absent", int'(d), 0);
        count_high(20, h);    check("beep_absent_sound", h, 0);
`endif

        bus_write(8'h01, 8'h07, 4);
        bus_write(8'h02, 8'h12, 4);
        if (BEEP_ON) bus_write(8'h06, 8'd200, 4);
        addr = 8'h01; cs = 1'b1; rd = 1'b1;
        tick(S + 1);
        for (int i = 0; i < 40 && !snd; i++) tick(1);
        check("pre_rst_sound", int'(snd), 1);
        check("pre_rst_rddat", int'(rddat), 8'h07);
        rst = 1'b1; cs = 1'b0; rd = 1'b0;
        model_reset();
        #1;
        check("mid_rst_sound", int'(snd), 0);
        check("mid_rst_led", int'(led), 8'h55);
        check("mid_rst_lcd_rst", int'(lcd_rst), 0);
        check("mid_rst_lcd_bk", int'(lcd_bk), 0);
        check("mid_rst_rddat", int'(rddat), 0);
        tick(1);
        rst = 1'b0;
        count_high(30, h);    check("post_rst_silent", h, 0);
        bus_read(8'h01, d);   check("post_rst_ctrl", int'(d), 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mcu_reg_bank.md
# mcu_reg_bank

Clocked, parametrised successor of the MCU-bus peripheral register file. Samples the asynchronous 8051 external-bus strobes into the `clk_i` domain and turns each write strobe into exactly one register write. Drives the LED, LCD and sound outputs. Adds a programmable tone generator and an optional self-timed beep. Sits between the CPLD's MCU bus decoder and the board peripherals.

## Interface
- `VERSION`, 8'h55: value returned at address 0x00.
- `LED_W`, 8: LED output width, 1..8.
- `LED_RST`, 8'h55: reset value of the LED register; only the low `LED_W` bits are used.
- `SYNC_STAGES`, 2: synchroniser depth for `mcu_cs_i`, `mcu_rd_i` and `mcu_wr_i`; minimum 2.
- `TICK_DIV`, 50000: beep timebase, in `clk_i` cycles per tick.
- `clk_i` in 1: system clock.
- `mcu_rst_i` in 1: asynchronous, active-high reset.
- `mcu_cs_i`, `mcu_rd_i`, `mcu_wr_i` in 1 each: asynchronous MCU bus strobes, active-high.
- `mcu_addr_i8` in 8: register address; stable while a strobe is high.
- `mcu_wrdat_i8` in 8: write data; stable while `mcu_wr_i` is high.
- `mcu_rddat_o8` out 8: read data, registered.
- `sound_o` out 1: buzzer drive.
- `led_o` out `LED_W`: LED drive.
- `lcd_rst_o` out 1: LCD reset.
- `lcd_bk_o` out 1: LCD backlight.

## Operation
- `wr_q` is `mcu_cs_i & mcu_wr_i` after the synchroniser. `rd_q` is `mcu_cs_i & mcu_rd_i` after the synchroniser.
- A 0→1 transition of `wr_q` produces a one-cycle `wr_stb`. A strobe held high for any length gives exactly one write.
- Address and write data are captured on the `wr_stb` cycle. They have been stable for at least `SYNC_STAGES` cycles by then.
- Register map (full 8-bit decode, all registers read/write unless stated):
  - 0x00 ID: read-only, returns `VERSION`.
  - 0x01 CTRL: bit0 `sound_en`, bit1 `lcd_rst`, bit2 `lcd_bk`; bits 7:3 read 0.
  - 0x02 LED: `led_o`; unused high bits read 0.
  - 0x03 TONE_L and 0x04 TONE_H: 16-bit `tone_div`.
  - 0x05 SCRATCH: 8-bit scratch register.
  - 0x06 BEEP: remaining beep ticks.
  - Unmapped addresses read 0; writes to them are ignored.
- Reads:
  - While `rd_q` is high, `mcu_rddat_o8` is reloaded every cycle from the map.
  - While `rd_q` is low, `mcu_rddat_o8` is 0.
- Tone generator:
  - 16-bit counter counts 0..`tone_div`, then wraps to 0 and toggles `tone`.
  - `sound_o` = `tone & sound_active`, where `sound_active` = `sound_en | (beep_cnt != 0)`.
  - Tone period is 2×(`tone_div`+1) clocks.
  - `tone_div` = 0: `sound_o` is held 0.
- Any write to TONE_L or TONE_H clears the counter and `tone`. Each byte takes effect on its own; no staging.

## Timing
- Reset values:
  - `mcu_rddat_o8` = 0, `sound_o` = 0, `led_o` = `LED_RST[LED_W-1:0]`, `lcd_rst_o` = 0, `lcd_bk_o` = 0.
  - CTRL = 0, `tone_div` = 0, SCRATCH = 0, `beep_cnt` = 0, tick prescaler = 0, synchronisers = 0.
- Write latency: the register output changes `SYNC_STAGES`+1 rising edges after `mcu_wr_i` rises (with `mcu_cs_i` already high).
- Read latency: data is valid `SYNC_STAGES`+1 edges after the `rd` rise. The MCU RD pulse must last at least `SYNC_STAGES`+2 clock periods.
- A read and a write high together: the write occurs. Read data shows the new value from the cycle after the write.
- Asserting `mcu_rst_i` mid-beep or mid-tone returns every output to its reset value immediately (asynchronously).

## Configuration
- `MCU_REG_BEEP_EN` defined:
  - A write to BEEP loads `beep_cnt` with the data and clears the tick prescaler.
  - `beep_cnt` decrements once every `TICK_DIV` clocks and saturates at 0.
  - A write while a beep is running restarts it with the new count.
  - A write of 0 cancels the beep.
- Not defined: BEEP reads 0, writes are ignored, no prescaler or counter is built, and `sound_active` = `sound_en`.

## Structure
- Package `mcu_reg_pkg` holds the address constants (`ADDR_ID` … `ADDR_BEEP`) and the CTRL bit indices (`CTRL_SOUND`, `CTRL_LCDRST`, `CTRL_LCDBK`).
- One sub-module, `mcu_bus_sync`: synchroniser chains for `cs`, `rd` and `wr`, plus the `wr_stb` edge detector. Outputs are `rd_q` and `wr_stb`.

## Test plan
- Reset, then read every address 0x00–0x07 → 0x55, 0x00, 0x55, 0x00, 0x00, 0x00, 0x00, 0x00; `led_o` = 0x55.
- Write 0xA5 to LED with `mcu_wr_i` held 40 clocks → exactly one write; `led_o` = 0xA5 at `SYNC_STAGES`+1 edges; CTRL unchanged.
- TONE_H = 0x00, TONE_L = 0x04, CTRL = 0x01 → `sound_o` square wave, period 10 clocks; write CTRL = 0 → `sound_o` = 0.
- With `MCU_REG_BEEP_EN`, `TICK_DIV` = 4, `tone_div` = 1, write BEEP = 3 → tone for 12 clocks; BEEP reads 3, 2, 1, 0; then silence.
- Rewrite BEEP = 5 while 2 ticks remain → count restarts at 5; build without the macro → BEEP reads 0 and `sound_o` stays 0.
- Assert `mcu_rst_i` for 1 clock mid-beep → all outputs reset in the same cycle; after release the tone stays off.
